// File: rtl/fnd_pkg.sv
// fnd_pkg: active-low glyph constants, blank pattern, frame data type and scan divider helper
package fnd_pkg;
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  blink;
  } fnd_data_t;
  function automatic int div_calc(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction
endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// fnd_scan_ctrl_if: display bus; master drives bcd_in/dp_in/blink_in/lz_en/load, slave drives scan_idx/seg/dp/frame_start
interface fnd_scan_ctrl_if;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_in;
  logic        lz_en;
  logic        load;
  logic [2:0]  scan_idx;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;
  modport master (
    output bcd_in, dp_in, blink_in, lz_en, load,
    input  scan_idx, seg, dp, frame_start
  );
  modport slave (
    input  bcd_in, dp_in, blink_in, lz_en, load,
    output scan_idx, seg, dp, frame_start
  );
endinterface

// File: rtl/fnd_bcd_to_seg.sv
// fnd_bcd_to_seg: combinational nibble (nib_i) to active-low {g..a} glyph (seg_o), hex A-F included
module fnd_bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (nib_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      default: seg_o = GLYPH_F;
    endcase
  end
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit FND scan controller; clk/reset plus slave bus (data/load in, scan_idx/seg/dp/frame_start out)
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 4000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic           clk,
  input  logic           reset,
  fnd_scan_ctrl_if.slave bus
);
  localparam int DIV = div_calc(CLK_HZ, SCAN_HZ);
  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0] idx_q, idx_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [BW-1:0] bc_q, bc_d;
  fnd_data_t shd_q, shd_d, act_q, act_d, bus_data;
  logic pend_q, pend_d, ph_q, ph_d, fs_q, fs_d, dp_q, dp_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic tick, wrap, z1, z2, z3, lz_off, off;
  logic [1:0] dig;
  logic [3:0] nib;
  assign bus_data = {bus.bcd_in, bus.dp_in, bus.blink_in};
  assign tick = pre_q == PW'(DIV - 1);
  assign wrap = tick && idx_q == 3'd7;
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = tick ? idx_q + 3'd1 : idx_q;
    dead_d = tick ? DW'(DEAD_CYC) : (dead_q != '0) ? dead_q - 1'b1 : dead_q;
    shd_d = bus.load ? bus_data : shd_q;
    act_d = !wrap ? act_q : bus.load ? bus_data : pend_q ? shd_q : act_q;
    pend_d = !wrap && (bus.load || pend_q);
    bc_d = !wrap ? bc_q : (bc_q == BW'(BLINK_FRAMES - 1)) ? '0 : bc_q + 1'b1;
    ph_d = ph_q ^ (wrap && bc_q == BW'(BLINK_FRAMES - 1));
    fs_d = wrap;
  end
  // display is derived from next-state values so seg/dp land with the new scan_idx
  assign dig = idx_d[1:0];
  assign nib = act_d.bcd[{dig, 2'b00} +: 4];
  assign z3 = act_d.bcd[15:12] == 4'h0;
  assign z2 = z3 && act_d.bcd[11:8] == 4'h0;
  assign z1 = z2 && act_d.bcd[7:4] == 4'h0;
  assign lz_off = bus.lz_en && (dig == 2'd1 ? z1 : dig == 2'd2 ? z2 : dig == 2'd3 ? z3 : 1'b0);
  assign off = dead_d != '0 || (ph_d && act_d.blink[dig]);
  assign seg_d = (off || lz_off) ? SEG_BLANK : glyph;
  assign dp_d = off || !act_d.dp[dig];
  fnd_bcd_to_seg u_enc (
    .nib_i(nib),
    .seg_o(glyph)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      dead_q <= DW'(DEAD_CYC);
      bc_q <= '0;
      shd_q <= '0;
      act_q <= '0;
      pend_q <= 1'b0;
      ph_q <= 1'b0;
      fs_q <= 1'b0;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      dead_q <= dead_d;
      bc_q <= bc_d;
      shd_q <= shd_d;
      act_q <= act_d;
      pend_q <= pend_d;
      ph_q <= ph_d;
      fs_q <= fs_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign bus.scan_idx = idx_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.frame_start = fs_q;
endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Time-multiplexing controller for the 4-digit seven-segment (FND) display. It sits directly upstream of the anode-select decoder and feeds its 3-bit input. The block generates the refresh cadence, a free-running 3-bit scan index, and the matching active-low segment/dp pattern. It also provides tear-free frame-synchronous data loading, leading-zero suppression, per-digit blink and anti-ghost dead time.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
SCAN_HZ, 4000, scan-slot rate in Hz; DIV = CLK_HZ/SCAN_HZ; DIV must be >= DEAD_CYC+2
DEAD_CYC, 16, blanking cycles after every scan_idx change
BLINK_FRAMES, 250, frames per blink half-period (1 frame = 8 slots)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
bcd_in  in  16  four nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3
dp_in  in  4  decimal point request per digit, active-high
blink_in  in  4  blink enable per digit
lz_en  in  1  leading-zero suppression enable (static level)
load  in  1  one-cycle strobe, captures bcd_in/dp_in/blink_in
scan_idx  out  3  scan index to anode decoder; digit = scan_idx[1:0]
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse when scan_idx becomes 0

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - prescaler 0, scan_idx 0, seg 7'h7F, dp 1, frame_start 0.
  - shadow and active data regs 0, pending 0, blink_phase 0, blink count 0.
  - dead counter loaded with DEAD_CYC, so output is blanked for DEAD_CYC cycles after reset release.
- Prescaler: counts 0..DIV-1 and wraps. tick = (count == DIV-1).
- On tick: scan_idx <= scan_idx+1, wrapping 7->0. Slots 4..7 repeat digits 0..3.
- Every scan_idx change reloads the dead counter with DEAD_CYC. While it is nonzero: seg = 7'h7F, dp = 1, and the counter decrements.
- frame_start: registered. It is 1 exactly on the cycle scan_idx first shows 0 after a 7->0 wrap; it is not asserted at reset.
- Loading:
  - A load strobe writes the inputs into the shadow regs and sets pending. A later load overwrites the shadow.
  - On the 7->0 wrap tick, if pending: active <= shadow and pending is cleared.
  - If load and the wrap tick occur in the same cycle: active takes the bus inputs directly, the shadow is also written, and pending ends at 0.
  - Active data never changes mid-frame.
- Glyph: nibble 0-9 shows the decimal glyph, 10-15 shows hex A,b,C,d,E,F. Examples: '0' = 7'h40, '1' = 7'h79, '8' = 7'h00.
- Leading-zero suppression (lz_en=1): digit k (k = 1..3) is blanked when its nibble and all higher nibbles are 0. Digit 0 is never blanked. A suppressed digit's dp still follows dp_in.
- Blink:
  - The frame counter counts 7->0 wraps. Every BLINK_FRAMES wraps, blink_phase toggles and the counter clears.
  - blink_phase=1 with the active blink bit set blanks that digit entirely (seg 7'h7F, dp 1).
- Timing: seg/dp are registered and computed from the next scan_idx, so they align with scan_idx in the same cycle (zero relative latency).
- Reset asserted mid-frame: all state returns to reset values on the next edge. Any pending load is discarded.

Decomposition:
- Package fnd_pkg: glyph constants GLYPH_0..GLYPH_F (7-bit, active-low), SEG_BLANK = 7'h7F, function div_calc(CLK_HZ, SCAN_HZ).
- One sub-module, fnd_bcd_to_seg: combinational 4-bit -> 7-bit glyph encoder, instantiated once on the selected nibble.
- Prescaler, scan, dead-time, load and blink logic stay in fnd_scan_ctrl.

Test Plan:
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (DIV=10), DEAD_CYC=2, BLINK_FRAMES=2.
1. Reset release -> scan_idx steps 0,1,..,7,0 every 10 clk. seg=7'h7F for the first 2 cycles after each change. frame_start pulses once per 80 clk, only at each 7->0.
2. Load bcd_in=16'h1234 mid-frame (scan_idx=3) -> the displayed data is unchanged until the wrap. After the wrap, slot 0 shows seg=7'h19 ('4') and slot 3 shows 7'h79 ('1').
3. load asserted on the exact 7->0 tick with 16'h00A7 -> slot 0 in that same frame shows 7'h78 ('7'). pending=0 afterwards.
4. lz_en=1, bcd=16'h0005 -> slots 1..3 seg=7'h7F, slot 0 seg=7'h12. With bcd=16'h0000 -> slot 0 seg=7'h40.
5. blink_in=4'b0001, dp_in=4'b0001 -> digit 0 is shown for 2 frames, then seg=7'h7F and dp=1 for 2 frames, alternating. Other digits are unaffected.
6. Reset pulsed mid-frame with a load pending -> next cycle scan_idx=0, seg=7'h7F, and active data 0 (slot 0 shows '0' once dead time ends).
